// File: rtl/relay_chain.sv
// relay_chain: clocked model of a chain of electromechanical relays with
// finite pull-in and drop-out times, per-stage battery and NO/NC contact
// selection, glitch rejection, a settle flag and an output edge counter.
//
// Parameters
//   STAGES      number of relays in the chain (>= 1)
//   PULL_CYCLES consecutive coil-high samples to engage an armature (>= 1)
//   DROP_CYCLES consecutive coil-low samples to release an armature (>= 1)
//   CNT_W       width of the saturating rising-edge counter on out
//
// Ports
//   clk         clock, rising edge
//   rst_n       asynchronous active-low reset
//   switch_in   coil drive of stage 0
//   batt        per-stage battery enable, gates contact[i]
//   nc_mode     per-stage normally-closed contact select
//   count_clr   synchronous clear of edge_count (wins over an edge)
//   contact     per-stage contact outputs
//   out         contact of the last stage
//   settled     no armature transition pending anywhere in the chain
//   edge_count  saturating count of out rising edges
module relay_chain #(
  parameter int STAGES      = 2,
  parameter int PULL_CYCLES = 3,
  parameter int DROP_CYCLES = 2,
  parameter int CNT_W       = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              switch_in,
  input  logic [STAGES-1:0] batt,
  input  logic [STAGES-1:0] nc_mode,
  input  logic              count_clr,
  output logic [STAGES-1:0] contact,
  output logic              out,
  output logic              settled,
  output logic [CNT_W-1:0]  edge_count
);

  localparam int MAX_RUN = (PULL_CYCLES > DROP_CYCLES) ? PULL_CYCLES : DROP_CYCLES;
  localparam int RUN_W   = $clog2(MAX_RUN + 1);

  localparam logic [RUN_W-1:0] RUN_ONE   = RUN_W'(1);
  localparam logic [RUN_W-1:0] PULL_LAST = RUN_W'(PULL_CYCLES);
  localparam logic [RUN_W-1:0] DROP_LAST = RUN_W'(DROP_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  localparam logic [1:0] ST_RELEASED = 2'd0;
  localparam logic [1:0] ST_PULLING  = 2'd1;
  localparam logic [1:0] ST_ENGAGED  = 2'd2;
  localparam logic [1:0] ST_DROPPING = 2'd3;

  logic [1:0]       state_q [STAGES];
  logic [1:0]       state_d [STAGES];
  logic [RUN_W-1:0] run_q   [STAGES];
  logic [RUN_W-1:0] run_d   [STAGES];
  logic [STAGES-1:0] armature;
  logic [STAGES-1:0] coil;
  logic              out_q;
  logic [CNT_W-1:0]  edge_count_q;

  // The armature is up while engaged and while a drop run is pending.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; otherwise synthesis would infer a latch.
    armature = '0;
    for (int i = 0; i < STAGES; i++) begin
      armature[i] = (state_q[i] == ST_ENGAGED) || (state_q[i] == ST_DROPPING);
    end
  end

  assign contact = batt & (armature ^ nc_mode);
  assign out     = contact[STAGES-1];

  // Each coil is fed by the previous contact; this is not a loop because
  // contacts derive only from registered armature state.
  always_comb begin
    coil    = '0;
    coil[0] = switch_in;
    for (int i = 1; i < STAGES; i++) begin
      coil[i] = contact[i-1];
    end
  end

  // Per-stage debounce FSM: a run of coil samples opposing the armature must
  // reach its full length before the armature moves; a shorter run aborts.
  always_comb begin
    for (int i = 0; i < STAGES; i++) begin
      state_d[i] = state_q[i];
      run_d[i]   = run_q[i];
      case (state_q[i])
        ST_RELEASED: begin
          if (coil[i]) begin
            if (PULL_CYCLES == 1) begin
              state_d[i] = ST_ENGAGED;
              run_d[i]   = '0;
            end else begin
              state_d[i] = ST_PULLING;
              run_d[i]   = RUN_ONE;
            end
          end
        end
        ST_PULLING: begin
          if (!coil[i]) begin
            state_d[i] = ST_RELEASED;
            run_d[i]   = '0;
          end else if (run_q[i] + RUN_ONE == PULL_LAST) begin
            state_d[i] = ST_ENGAGED;
            run_d[i]   = '0;
          end else begin
            run_d[i]   = run_q[i] + RUN_ONE;
          end
        end
        ST_ENGAGED: begin
          if (!coil[i]) begin
            if (DROP_CYCLES == 1) begin
              state_d[i] = ST_RELEASED;
              run_d[i]   = '0;
            end else begin
              state_d[i] = ST_DROPPING;
              run_d[i]   = RUN_ONE;
            end
          end
        end
        default: begin // ST_DROPPING
          if (coil[i]) begin
            state_d[i] = ST_ENGAGED;
            run_d[i]   = '0;
          end else if (run_q[i] + RUN_ONE == DROP_LAST) begin
            state_d[i] = ST_RELEASED;
            run_d[i]   = '0;
          end else begin
            run_d[i]   = run_q[i] + RUN_ONE;
          end
        end
      endcase
    end
  end

  always_comb begin
    settled = 1'b1;
    for (int i = 0; i < STAGES; i++) begin
      if ((state_q[i] == ST_PULLING) || (state_q[i] == ST_DROPPING) ||
          (armature[i] != coil[i])) begin
        settled = 1'b0;
      end
    end
  end

  // NOTE: the per-stage arrays are control state, not storage, so every
  // element is reset; a mid-run reset must discard any partial run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        state_q[i] <= ST_RELEASED;
        run_q[i]   <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments so every stage samples the pre-edge
      // contacts of its neighbour, like real relays switching together.
      for (int i = 0; i < STAGES; i++) begin
        state_q[i] <= state_d[i];
        run_q[i]   <= run_d[i];
      end
    end
  end

  // Rising-edge counter on out, one cycle behind out; clear beats an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q        <= 1'b0;
      edge_count_q <= '0;
    end else begin
      out_q <= out;
      if (count_clr) begin
        edge_count_q <= '0;
      end else if (out && !out_q && (edge_count_q != CNT_MAX)) begin
        edge_count_q <= edge_count_q + CNT_W'(1);
      end
    end
  end

  assign edge_count = edge_count_q;

endmodule
